// File: rtl/jt89_regs.sv
// SN76489 latch/data register front end: tone periods, attenuations, noise control.
// Optional READY busy handshake enabled by defining JT89_READY_EN.
module jt89_regs (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [7:0] din,
    input  logic       wr_n,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [3:0] vol0,
    output logic [3:0] vol1,
    output logic [3:0] vol2,
    output logic [3:0] vol3,
    output logic [2:0] ctrl3,
    output logic       noise_rst,
    output logic       ready
);

    logic       wr_l_q;
    logic       ready_s;
    logic       write_s;
    logic [2:0] sel_s;
    logic [2:0] r_q, r_d;
    logic [9:0] tone_q [0:2];
    logic [9:0] tone_d [0:2];
    logic [3:0] vol_q  [0:3];
    logic [3:0] vol_d  [0:3];
    logic [2:0] ctrl3_q, ctrl3_d;
    logic       noise_rst_q, noise_rst_d;

    // wr_n history; it follows the pin even in reset (idle-high pin gives the
    // reset value 1), so a strobe held low across reset is not seen as an edge
    always_ff @(posedge clk) begin
        wr_l_q <= wr_n;
    end

    assign write_s = ~wr_n & wr_l_q & ready_s;
    assign sel_s   = din[7] ? din[6:4] : r_q;

    // decode one write into exactly one register field
    always_comb begin
        r_d         = r_q;
        tone_d      = tone_q;
        vol_d       = vol_q;
        ctrl3_d     = ctrl3_q;
        noise_rst_d = 1'b0;
        if (write_s) begin
            if (din[7]) begin
                r_d = din[6:4];
            end else begin
                r_d = r_q;
            end
            case (sel_s)
                3'd0, 3'd2, 3'd4: begin
                    if (din[7]) begin
                        tone_d[sel_s[2:1]][3:0] = din[3:0];
                    end else begin
                        tone_d[sel_s[2:1]][9:4] = din[5:0];
                    end
                end
                3'd1, 3'd3, 3'd5, 3'd7: begin
                    vol_d[sel_s[2:1]] = din[3:0];
                end
                3'd6: begin
                    ctrl3_d     = din[2:0];
                    noise_rst_d = 1'b1;
                end
                default: begin
                    r_d = r_q;
                end
            endcase
        end else begin
            r_d = r_q;
        end
    end

    // register state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= 3'd0;
            tone_q      <= '{10'd0, 10'd0, 10'd0};
            vol_q       <= '{4'hF, 4'hF, 4'hF, 4'hF};
            ctrl3_q     <= 3'd0;
            noise_rst_q <= 1'b0;
        end else begin
            r_q         <= r_d;
            tone_q      <= tone_d;
            vol_q       <= vol_d;
            ctrl3_q     <= ctrl3_d;
            noise_rst_q <= noise_rst_d;
        end
    end

`ifdef JT89_READY_EN
    logic       ready_q;
    logic [4:0] busy_q;

    // busy for 32 clk_en pulses after each accepted write
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b1;
            busy_q  <= 5'd0;
        end else if (write_s) begin
            ready_q <= 1'b0;
            busy_q  <= 5'd31;
        end else if (!ready_q && clk_en) begin
            if (busy_q == 5'd0) begin
                ready_q <= 1'b1;
            end else begin
                busy_q <= busy_q - 5'd1;
            end
        end else begin
            busy_q <= busy_q;
        end
    end

    assign ready_s = ready_q;
`else
    logic unused_clk_en_s;

    assign unused_clk_en_s = clk_en;
    assign ready_s         = 1'b1;
`endif

    assign tone0     = tone_q[0];
    assign tone1     = tone_q[1];
    assign tone2     = tone_q[2];
    assign vol0      = vol_q[0];
    assign vol1      = vol_q[1];
    assign vol2      = vol_q[2];
    assign vol3      = vol_q[3];
    assign ctrl3     = ctrl3_q;
    assign noise_rst = noise_rst_q;
    assign ready     = ready_s;

endmodule

// File: tb/tb_jt89_regs.sv
// Scoreboard bench for jt89_regs; READY checks are built when JT89_READY_EN is defined.
module tb_jt89_regs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_n = 1'b1;
    logic [9:0] tone0, tone1, tone2;
    logic [3:0] vol0, vol1, vol2, vol3;
    logic [2:0] ctrl3;
    logic       noise_rst, ready;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model of the register file
    logic [2:0] m_r;
    logic [9:0] m_tone [0:2];
    logic [3:0] m_vol  [0:3];
    logic [2:0] m_ctrl;
    logic [48:0] sb_q [$];

    jt89_regs dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .din(din), .wr_n(wr_n),
        .tone0(tone0), .tone1(tone1), .tone2(tone2),
        .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
        .ctrl3(ctrl3), .noise_rst(noise_rst), .ready(ready)
    );

    always #5 clk = ~clk;

    // clk_en high one cycle in four
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            clk_en = (k % 4 == 3);
            k++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] dut_state();
        return {tone0, tone1, tone2, vol0, vol1, vol2, vol3, ctrl3};
    endfunction

    function automatic logic [48:0] model_state();
        return {m_tone[0], m_tone[1], m_tone[2], m_vol[0], m_vol[1], m_vol[2], m_vol[3], m_ctrl};
    endfunction

    task automatic model_reset();
        m_r = 3'd0;
        for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
        for (int i = 0; i < 4; i++) m_vol[i] = 4'hF;
        m_ctrl = 3'd0;
    endtask

    task automatic model_write(input logic [7:0] d, output bit pulse);
        logic [2:0] sel;
        sel = d[7] ? d[6:4] : m_r;
        pulse = 1'b0;
        if (d[7]) m_r = d[6:4];
        if (sel == 3'd6) begin
            m_ctrl = d[2:0];
            pulse = 1'b1;
        end else if (sel[0]) begin
            m_vol[sel >> 1] = d[3:0];
        end else if (d[7]) begin
            m_tone[sel >> 1] = {m_tone[sel >> 1][9:4], d[3:0]};
        end else begin
            m_tone[sel >> 1] = {d[5:0], m_tone[sel >> 1][3:0]};
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (ready !== 1'b1 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 400) check_eq("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    // one accepted write: push expectation, strobe, pop and compare
    task automatic wr(input logic [7:0] d);
        bit pulse;
        logic [48:0] exp;
        wait_ready();
        model_write(d, pulse);
        sb_q.push_back(model_state());
        @(negedge clk);
        din = d;
        wr_n = 1'b0;
        @(posedge clk); #1;
        exp = sb_q.pop_front();
        check_eq($sformatf("state_%02h", d), {15'd0, dut_state()}, {15'd0, exp});
        check_eq($sformatf("nrst_%02h", d), {63'd0, noise_rst}, {63'd0, pulse});
        @(negedge clk);
        wr_n = 1'b1;
        @(posedge clk); #1;
        check_eq($sformatf("nrst_off_%02h", d), {63'd0, noise_rst}, 64'd0);
    endtask

    initial begin
        bit saw_pulse;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_pulse = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (noise_rst) saw_pulse = 1'b1;
        end
        check_eq("reset_state", {15'd0, dut_state()}, {15'd0, model_state()});
        check_eq("reset_ready", {63'd0, ready}, 64'd1);
        check_eq("reset_no_nrst", {63'd0, saw_pulse}, 64'd0);

        wr(8'h8E);
        wr(8'h0F);
        check_eq("tone0_0FE", {54'd0, tone0}, 64'h0FE);
        wr(8'h23);
        check_eq("tone0_23E", {54'd0, tone0}, 64'h23E);
        wr(8'h9A);
        check_eq("vol0_A", {60'd0, vol0}, 64'hA);
        wr(8'h05);
        check_eq("vol0_5", {60'd0, vol0}, 64'h5);
        wr(8'hFF);
        check_eq("vol3_F", {60'd0, vol3}, 64'hF);
        wr(8'hE5);
        check_eq("ctrl3_5", {61'd0, ctrl3}, 64'h5);
        wr(8'h02);
        check_eq("ctrl3_2", {61'd0, ctrl3}, 64'h2);
        wr(8'hB3);
        wr(8'h2A);
        wr(8'hD9);
        wr(8'h3F);

        // strobe held low: exactly one write
        wait_ready();
        begin
            bit p;
            model_write(8'hC7, p);
        end
        @(negedge clk);
        din = 8'hC7;
        wr_n = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("held_low_state", {15'd0, dut_state()}, {15'd0, model_state()});
        check_eq("held_low_tone2", {60'd0, tone2[3:0]}, 64'h7);

        // reset while strobe stays low: nothing written after release
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
        check_eq("rst_held_state", {15'd0, dut_state()}, {15'd0, model_state()});
        check_eq("rst_held_ready", {63'd0, ready}, 64'd1);
        wr_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef JT89_READY_EN
        begin
            int n_en;
            int t;
            n_en = 0;
            t = 0;
            @(negedge clk);
            din = 8'h81;
            wr_n = 1'b0;
            @(posedge clk); #1;
            check_eq("busy_after_wr", {63'd0, ready}, 64'd0);
            check_eq("tone0_1", {54'd0, tone0}, 64'h001);
            while (ready !== 1'b1 && t < 400) begin
                if (t == 2) wr_n = 1'b1;
                if (t == 40) begin
                    din = 8'h90;
                    wr_n = 1'b0;
                end
                if (t == 43) wr_n = 1'b1;
                @(posedge clk); #1;
                if (clk_en) n_en++;
                t++;
            end
            check_eq("busy_clk_en_count", 64'(n_en), 64'd32);
            check_eq("dropped_vol0", {60'd0, vol0}, 64'hF);
            m_tone[0] = 10'h001;
            m_r = 3'd0;
        end
        wr(8'h90);
        check_eq("vol0_0", {60'd0, vol0}, 64'h0);
        check_eq("busy_again", {63'd0, ready}, 64'd0);
`else
        wr(8'h81);
        wr(8'h90);
        check_eq("vol0_0", {60'd0, vol0}, 64'h0);
        check_eq("ready_const", {63'd0, ready}, 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
